// File: rtl/warmboot_sequencer_if.sv
// Loader handshake bundle between the warm-boot sequencer (master) and the
// bitstream/slot loader (slave).
interface warmboot_sequencer_if #(
  parameter int SLOT_W = 4
);
  logic              cfg_req_o;
  logic [SLOT_W-1:0] cfg_slot_o;
  logic              cfg_ack_i;

  modport master (
    output cfg_req_o,
    output cfg_slot_o,
    input  cfg_ack_i
  );

  modport slave (
    input  cfg_req_o,
    input  cfg_slot_o,
    output cfg_ack_i
  );
endinterface

// File: rtl/warmboot_sequencer.sv
// Warm-boot sequencer: stretches power-on reset, validates boot requests, runs the
// loader handshake with timeout and holds user logic in reset around each load.
module warmboot_sequencer #(
  parameter int SLOT_W         = 4,
  parameter int NUM_SLOTS      = 16,
  parameter int POR_CYCLES     = 8,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 boot_i,
  input  logic [SLOT_W-1:0]    slot_i,
  warmboot_sequencer_if.master cfg,
  output logic                 user_reset_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [SLOT_W-1:0]    last_slot_o
);

  localparam int MAX_AB = (POR_CYCLES > HOLD_CYCLES) ? POR_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_POR  = 2'd0,
    ST_RUN  = 2'd1,
    ST_REQ  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic               boot_q_r, boot_edge_s;
  logic               slot_ok_s;
  logic               cfg_req_r, cfg_req_s;
  logic [SLOT_W-1:0]  cfg_slot_r, cfg_slot_s;
  logic               user_reset_r, user_reset_s;
  logic               busy_r, busy_s;
  logic               err_r, err_s;
  logic [SLOT_W-1:0]  last_slot_r, last_slot_s;

  assign boot_edge_s = boot_i & ~boot_q_r;
  assign slot_ok_s   = (32'(slot_i) < 32'(NUM_SLOTS));
  // Saturating increment: a stuck phase must never wrap back into a short count.
  assign cnt_inc_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    cfg_req_s    = cfg_req_r;
    cfg_slot_s   = cfg_slot_r;
    user_reset_s = user_reset_r;
    err_s        = err_r;
    last_slot_s  = last_slot_r;
    case (state_r)
      ST_POR: begin
        if (cnt_r == CNT_W'(POR_CYCLES)) begin
          state_s      = ST_RUN;
          cnt_s        = {CNT_W{1'b0}};
          user_reset_s = 1'b0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_RUN: begin
        if (boot_edge_s) begin
          if (slot_ok_s) begin
            state_s      = ST_REQ;
            cnt_s        = {CNT_W{1'b0}};
            cfg_req_s    = 1'b1;
            cfg_slot_s   = slot_i;
            user_reset_s = 1'b1;
            err_s        = 1'b0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_REQ: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (cfg.cfg_ack_i) begin
          state_s     = ST_HOLD;
          cnt_s       = {CNT_W{1'b0}};
          cfg_req_s   = 1'b0;
          last_slot_s = cfg_slot_r;
        end else if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_s   = ST_HOLD;
          cnt_s     = {CNT_W{1'b0}};
          cfg_req_s = 1'b0;
          err_s     = 1'b1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_HOLD: begin
        if (cnt_r == CNT_W'(HOLD_CYCLES - 1)) begin
          state_s      = ST_RUN;
          cnt_s        = {CNT_W{1'b0}};
          user_reset_s = 1'b0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      default: begin
        state_s      = ST_POR;
        cnt_s        = {CNT_W{1'b0}};
        cfg_req_s    = 1'b0;
        user_reset_s = 1'b1;
      end
    endcase
    busy_s = (state_s != ST_RUN);
  end

  // State, counter, edge register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_POR;
      cnt_r        <= {CNT_W{1'b0}};
      boot_q_r     <= 1'b0;
      cfg_req_r    <= 1'b0;
      cfg_slot_r   <= {SLOT_W{1'b0}};
      user_reset_r <= 1'b1;
      busy_r       <= 1'b1;
      err_r        <= 1'b0;
      last_slot_r  <= {SLOT_W{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      boot_q_r     <= boot_i;
      cfg_req_r    <= cfg_req_s;
      cfg_slot_r   <= cfg_slot_s;
      user_reset_r <= user_reset_s;
      busy_r       <= busy_s;
      err_r        <= err_s;
      last_slot_r  <= last_slot_s;
    end
  end

  assign cfg.cfg_req_o  = cfg_req_r;
  assign cfg.cfg_slot_o = cfg_slot_r;
  assign user_reset_o   = user_reset_r;
  assign busy_o         = busy_r;
  assign err_o          = err_r;
  assign last_slot_o    = last_slot_r;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Self-checking bench for warmboot_sequencer: directed and randomized boot
// transactions with expectations derived from cycle arithmetic per transaction.
module tb_warmboot_sequencer;
  localparam int SLOT_W  = 4;
  localparam int NSLOTS  = 12;
  localparam int POR     = 8;
  localparam int HOLD    = 16;
  localparam int TIMEOUT = 32;

  logic              clk    = 1'b0;
  logic              rst_n  = 1'b0;
  logic              boot_i = 1'b0;
  logic [SLOT_W-1:0] slot_i = '0;
  logic              cfg_ack = 1'b0;
  logic              user_reset_o, busy_o, err_o;
  logic [SLOT_W-1:0] last_slot_o;

  warmboot_sequencer_if #(.SLOT_W(SLOT_W)) cfg_if ();
  assign cfg_if.cfg_ack_i = cfg_ack;

  warmboot_sequencer #(
    .SLOT_W(SLOT_W), .NUM_SLOTS(NSLOTS), .POR_CYCLES(POR),
    .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .boot_i(boot_i), .slot_i(slot_i), .cfg(cfg_if),
    .user_reset_o(user_reset_o), .busy_o(busy_o), .err_o(err_o), .last_slot_o(last_slot_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_slot = 0;
  int exp_err  = 0;
  int exp_last = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Busy mirrors user reset: both are high in every phase except normal running.
  task automatic check_all(input string tag, input int req, input int ureset);
    chk({tag, ".req"},   32'(cfg_if.cfg_req_o),  req);
    chk({tag, ".slot"},  32'(cfg_if.cfg_slot_o), exp_slot);
    chk({tag, ".ureset"}, 32'(user_reset_o),     ureset);
    chk({tag, ".busy"},  32'(busy_o),            ureset);
    chk({tag, ".err"},   32'(err_o),             exp_err);
    chk({tag, ".last"},  32'(last_slot_o),       exp_last);
  endtask

  task automatic por_seq();
    for (int k = 0; k <= POR; k++) begin
      tick();
      check_all("por", 0, (k < POR) ? 1 : 0);
    end
  endtask

  // One boot request; ack sampled on the d-th cycle after req rises (no ack if d
  // is 0 or beyond the timeout). hold_boot keeps boot_i high for the whole load.
  task automatic boot_txn(input int slot, input int d, input bit hold_boot, input bit ack_level);
    boot_i = 1'b1;
    slot_i = slot[SLOT_W-1:0];
    tick();
    if (slot >= NSLOTS) begin
      exp_err = 1;
      check_all("badslot", 0, 0);
      boot_i = 1'b0;
      tick();
      check_all("badslot_idle", 0, 0);
      return;
    end
    exp_slot = slot;
    exp_err  = 0;
    check_all("accept", 1, 1);
    for (int j = 1; j <= TIMEOUT; j++) begin
      if (!hold_boot) boot_i = 1'($urandom_range(0, 1));
      slot_i  = SLOT_W'($urandom);
      cfg_ack = (j == d);
      tick();
      if (j == d) begin
        exp_last = slot;
        check_all("ack", 0, 1);
        break;
      end else if (j == TIMEOUT) begin
        exp_err = 1;
        check_all("timeout", 0, 1);
      end else begin
        check_all("req_wait", 1, 1);
      end
    end
    if (!ack_level) cfg_ack = 1'b0;
    for (int k = 1; k <= HOLD; k++) begin
      if (!hold_boot) boot_i = 1'($urandom_range(0, 1));
      tick();
      check_all("hold", 0, (k < HOLD) ? 1 : 0);
    end
    cfg_ack = 1'b0;
    if (hold_boot) begin
      tick();
      check_all("held_no_retrigger", 0, 0);
    end
    boot_i = 1'b0;
    tick();
    check_all("idle", 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("reset", 0, 1);
    end
    rst_n = 1'b1;
    por_seq();

    boot_txn(5, 10, 1'b0, 1'b0);
    boot_txn(13, 0, 1'b0, 1'b0);
    boot_txn(2, int'($urandom_range(1, TIMEOUT - 1)), 1'b0, 1'b1);
    boot_txn(7, 0, 1'b0, 1'b0);
    boot_txn(9, TIMEOUT, 1'b0, 1'b0);
    boot_txn(3, 5, 1'b1, 1'b0);

    for (int n = 0; n < 12; n++) begin
      boot_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, TIMEOUT + 4)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset pulse while the loader request is outstanding.
    boot_i = 1'b1;
    slot_i = 4'd4;
    tick();
    exp_slot = 4;
    exp_err  = 0;
    check_all("mr_accept", 1, 1);
    boot_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("mr_req", 1, 1);
    end
    rst_n = 1'b0;
    tick();
    exp_slot = 0;
    exp_err  = 0;
    exp_last = 0;
    check_all("mr_reset", 0, 1);
    rst_n = 1'b1;
    por_seq();
    boot_txn(11, 4, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/warmboot_sequencer.md
Name: warmboot_sequencer

Overview:
Sits directly upstream of user logic in a fabric user design. It turns a boot request into a reconfiguration handshake with the bitstream/slot loader and owns the active-high user-logic reset. That reset replaces the fixed tie-off reset source for user counters and state. Provides power-on reset stretching, slot validation, loader timeout, and post-load reset hold.

Parameters:
SLOT_W, 4, width of slot index
NUM_SLOTS, 16, number of valid slots; slot_i >= NUM_SLOTS is rejected
POR_CYCLES, 8, cycles user_reset_o stays high after rst_n release (>=1)
HOLD_CYCLES, 16, cycles user_reset_o stays high after loader ack or timeout (>=1)
TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for cfg_ack_i

Ports:
clk  input  1  fabric clock; all logic on rising edge
rst_n  input  1  synchronous, active-low reset
boot_i  input  1  boot request level; a rising edge triggers a request
slot_i  input  SLOT_W  requested slot, sampled on the boot_i rising edge
cfg_req_o  output  1  request to loader; held until ack or timeout
cfg_slot_o  output  SLOT_W  slot presented to loader; stable while cfg_req_o=1
cfg_ack_i  input  1  loader done; single-cycle or level, sampled only in REQ
user_reset_o  output  1  active-high reset to user logic
busy_o  output  1  high whenever state != RUN
err_o  output  1  sticky error (bad slot or timeout); cleared by the next accepted request
last_slot_o  output  SLOT_W  slot of the last successful load

Behaviour:
- One clock; reset is synchronous and active-low. rst_n=0 at an edge sets: state=POR, user_reset_o=1, busy_o=1, cfg_req_o=0, cfg_slot_o=0, err_o=0, last_slot_o=0, counters=0, boot edge register=0.
- All outputs are registered; no combinational input-to-output paths.
- States: POR, RUN, REQ, HOLD.
- POR:
  - Counts POR_CYCLES edges with rst_n=1.
  - At the edge where the count reaches POR_CYCLES, state goes to RUN and user_reset_o goes to 0.
  - user_reset_o is low from cycle POR_CYCLES, where cycle 0 is the first edge after release.
- Edge detect:
  - boot_q is registered every cycle in all states.
  - A rising edge is boot_i=1 & boot_q=0.
  - A level held high never retriggers.
  - Edges seen outside RUN are ignored and are not queued.
- RUN, on a rising edge:
  - slot_i < NUM_SLOTS: latch cfg_slot_o=slot_i and clear err_o. Next cycle: state=REQ, cfg_req_o=1, user_reset_o=1, busy_o=1.
  - slot_i >= NUM_SLOTS: err_o=1 next cycle. Stay in RUN; user_reset_o and cfg_req_o are untouched.
- REQ:
  - Timeout counter increments each cycle.
  - cfg_ack_i=1 sampled: next cycle cfg_req_o=0, last_slot_o=cfg_slot_o, state=HOLD, counter cleared.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: next cycle cfg_req_o=0, err_o=1, state=HOLD; last_slot_o is unchanged.
  - Ack and timeout on the same cycle: ack wins, err_o is not set.
- HOLD:
  - user_reset_o stays 1 for exactly HOLD_CYCLES cycles, then state=RUN and user_reset_o=0.
  - cfg_ack_i is ignored in HOLD.
- Worked latency (ack sampled at edge m): cfg_req_o low at m+1; user_reset_o low at m+1+HOLD_CYCLES.
- rst_n low mid-operation, in any state: immediate return to POR values next edge. cfg_req_o drops even without ack; last_slot_o and err_o clear.
- Counters are sized clog2 of the largest parameter + 1 and saturate rather than wrap.

Test Plan:
- Power-on: rst_n low 3 cycles, then high -> user_reset_o=1 for 8 cycles, 0 at cycle 8; busy_o tracks it; all other outputs 0.
- Good boot: in RUN, boot_i 0->1 with slot_i=5; loader acks 10 cycles after cfg_req_o rises -> cfg_slot_o=5; cfg_req_o high for 10 cycles; user_reset_o low 16 cycles after req drops; last_slot_o=5; err_o=0.
- Bad slot: NUM_SLOTS=12, boot edge with slot_i=13 -> err_o=1; cfg_req_o stays 0; user_reset_o stays 0. Then a boot edge with slot 2 -> err_o clears and a normal load completes.
- Timeout: TIMEOUT_CYCLES=32, no ack -> cfg_req_o high exactly 32 cycles, err_o=1, HOLD for 16 cycles, last_slot_o unchanged. Ack arriving on cycle 32 exactly -> treated as success.
- Held/ignored requests: boot_i held high through a load and back to RUN -> no second request. Boot edges during REQ/HOLD -> ignored.
- Reset mid-REQ: rst_n pulsed low while cfg_req_o=1 -> next edge cfg_req_o=0, user_reset_o=1, state POR, last_slot_o=0; POR sequence repeats.
